// File: rtl/pu_asm_enc.sv
// pu_asm_enc: packs field-level commands into 16-bit PU instructions and
// writes them into instruction memory. LI16 becomes two words. The PU is
// held until END. Ports: clk, rst_n, start, cmd_* (valid/ready command),
// im_we/im_addr/im_wdata (memory write), im_count, busy, done, err, pu_hold.
module pu_asm_enc #(
  parameter int ADDR_W = 8,
  parameter int BASE   = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [3:0]        cmd_cls,
  input  logic [1:0]        cmd_rw,
  input  logic [1:0]        cmd_ra,
  input  logic [1:0]        cmd_rb,
  input  logic [3:0]        cmd_op,
  input  logic [2:0]        cmd_cond,
  input  logic [15:0]       cmd_imm,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [15:0]       im_wdata,
  output logic [ADDR_W-1:0] im_count,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              pu_hold
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_EXP2 = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam int LIMI = (1 << ADDR_W) - BASE;
  localparam logic [ADDR_W:0]   LIM    = LIMI[ADDR_W:0];
  localparam logic [ADDR_W-1:0] BASE_A = BASE[ADDR_W-1:0];

  logic [1:0]        state;
  logic [ADDR_W:0]   cnt_q;
  logic [ADDR_W-1:0] wptr;
  logic [1:0]        li_rw;
  logic [7:0]        li_hi;

  logic        accept;
  logic        sx_ok;
  logic        chk;
  logic        bad;
  logic        full;
  logic        wr_req;
  logic [15:0] word;
  logic [15:0] wr_word;
  logic [7:0]  imm8;

  assign imm8      = cmd_imm[7:0];
  assign sx_ok     = cmd_imm[15:8] == {8{cmd_imm[7]}};
  assign cmd_ready = (state == S_RUN) & ~start;
  assign accept    = cmd_valid & cmd_ready;
  assign full      = cnt_q == LIM;
  assign busy      = (state == S_RUN) | (state == S_EXP2);
  assign pu_hold   = state != S_DONE;
  assign im_count  = cnt_q[ADDR_W-1:0];

  always_comb begin
    word = 16'h0000;
    chk  = 1'b0;
    bad  = 1'b0;
    unique case (1'b1)
      cmd_cls == 4'h0: word = 16'h0000;
      cmd_cls == 4'h1: word = 16'h0001;
      cmd_cls == 4'h2: begin
        word = {6'b000001, cmd_rw, imm8};
        chk  = 1'b1;
      end
      cmd_cls == 4'h3:
        word = {6'b001010, cmd_rw, cmd_op, cmd_ra, cmd_rb};
      cmd_cls == 4'h4: begin
        word = {4'b1100, cmd_rw, cmd_ra, imm8};
        chk  = 1'b1;
      end
      cmd_cls == 4'h5: begin
        word = {4'b1101, cmd_rw, cmd_ra, imm8};
        chk  = 1'b1;
      end
      cmd_cls == 4'h6: begin
        word = {4'b1011, cmd_rw, cmd_ra, imm8};
        chk  = 1'b1;
      end
      cmd_cls == 4'h7: begin
        word = {4'b1001, cmd_ra, cmd_rb, imm8};
        chk  = 1'b1;
      end
      cmd_cls == 4'h8: begin
        word = {5'b00100, cmd_cond, imm8};
        chk  = 1'b1;
      end
      cmd_cls == 4'h9: begin
        word = {3'b111, cmd_ra, cmd_cond, imm8};
        chk  = 1'b1;
      end
      cmd_cls == 4'hA:
        word = {12'h011, cmd_ra, cmd_rb};
      cmd_cls == 4'hB:
        word = {4'b0100, cmd_rw, cmd_rb, imm8};
      cmd_cls == 4'hC:
        word = {4'b0101, cmd_rw, cmd_rb, imm8};
      cmd_cls == 4'hD:
        word = {4'b0100, cmd_rw, cmd_rw, imm8};
      cmd_cls == 4'hE: word = 16'h0001;
      cmd_cls == 4'hF: bad = 1'b1;
      default: bad = 1'b1;
    endcase
    if (chk && !sx_ok) bad = 1'b1;
  end

  // second LI16 word comes from the latched register/high byte
  assign wr_req  = (accept & ~bad) |
                   ((state == S_EXP2) & ~start);
  assign wr_word = (state == S_EXP2) ?
                   {4'b0101, li_rw, li_rw, li_hi} : word;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      cnt_q    <= '0;
      wptr     <= '0;
      li_rw    <= '0;
      li_hi    <= '0;
      im_we    <= 1'b0;
      im_addr  <= '0;
      im_wdata <= '0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else if (start) begin
      state   <= S_RUN;
      cnt_q   <= '0;
      wptr    <= BASE_A;
      im_we   <= 1'b0;
      im_addr <= BASE_A;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      im_we <= wr_req & ~full;
      if (wr_req) begin
        if (full) begin
          err <= 1'b1;
        end else begin
          im_wdata <= wr_word;
          im_addr  <= wptr;
          wptr     <= wptr + 1'b1;
          cnt_q    <= cnt_q + 1'b1;
        end
      end
      if (accept && bad) err <= 1'b1;
      if (state == S_EXP2) state <= S_RUN;
      if (accept && !bad) begin
        if (cmd_cls == 4'hD) begin
          state <= S_EXP2;
          li_rw <= cmd_rw;
          li_hi <= cmd_imm[15:8];
        end
        if (cmd_cls == 4'hE) begin
          state <= S_DONE;
          done  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_pu_asm_enc.sv
// tb_pu_asm_enc: directed vectors, expected words queued at issue time and
// checked by monitors whenever im_we is seen.
module tb_pu_asm_enc;

  typedef struct {
    logic [7:0]  a;
    logic [15:0] d;
    logic [7:0]  c;
  } exp_t;

  logic        clk = 0;
  logic        rst_n = 0;
  logic        start = 0, start2 = 0;
  logic        cmd_valid = 0, cmd_valid2 = 0;
  logic [3:0]  cmd_cls = 0;
  logic [1:0]  cmd_rw = 0, cmd_ra = 0, cmd_rb = 0;
  logic [3:0]  cmd_op = 0;
  logic [2:0]  cmd_cond = 0;
  logic [15:0] cmd_imm = 0;

  logic        rdy, we, busy, done, err, hold;
  logic [7:0]  addr, cnt;
  logic [15:0] wd;
  logic        rdy2, we2, busy2, done2, err2, hold2;
  logic [1:0]  addr2, cnt2;
  logic [15:0] wd2;

  int checks = 0;
  int failures = 0;
  int n2 = 0;
  exp_t q[$];
  exp_t q2[$];

  always #5 clk = ~clk;

  pu_asm_enc #(.ADDR_W(8), .BASE(0)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .cmd_valid(cmd_valid), .cmd_ready(rdy),
    .cmd_cls(cmd_cls), .cmd_rw(cmd_rw), .cmd_ra(cmd_ra),
    .cmd_rb(cmd_rb), .cmd_op(cmd_op), .cmd_cond(cmd_cond),
    .cmd_imm(cmd_imm), .im_we(we), .im_addr(addr),
    .im_wdata(wd), .im_count(cnt), .busy(busy),
    .done(done), .err(err), .pu_hold(hold)
  );

  pu_asm_enc #(.ADDR_W(2), .BASE(0)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2),
    .cmd_valid(cmd_valid2), .cmd_ready(rdy2),
    .cmd_cls(cmd_cls), .cmd_rw(cmd_rw), .cmd_ra(cmd_ra),
    .cmd_rb(cmd_rb), .cmd_op(cmd_op), .cmd_cond(cmd_cond),
    .cmd_imm(cmd_imm), .im_we(we2), .im_addr(addr2),
    .im_wdata(wd2), .im_count(cnt2), .busy(busy2),
    .done(done2), .err(err2), .pu_hold(hold2)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] a, input logic [15:0] d,
                      input logic [7:0] c);
    exp_t e;
    e.a = a; e.d = d; e.c = c;
    q.push_back(e);
  endtask

  task automatic push2(input logic [7:0] a, input logic [15:0] d,
                       input logic [7:0] c);
    exp_t e;
    e.a = a; e.d = d; e.c = c;
    q2.push_back(e);
  endtask

  always @(negedge clk) begin
    if (we) begin
      if (q.size() == 0) begin
        chk("unexpected_we", {16'h0, wd}, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("wr_addr", {24'h0, addr}, {24'h0, e.a});
        chk("wr_data", {16'h0, wd}, {16'h0, e.d});
        chk("wr_count", {24'h0, cnt}, {24'h0, e.c});
      end
    end
    if (we2) begin
      n2++;
      if (q2.size() == 0) begin
        chk("unexpected_we2", {16'h0, wd2}, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = q2.pop_front();
        chk("wr2_addr", {30'h0, addr2}, {24'h0, e.a});
        chk("wr2_data", {16'h0, wd2}, {16'h0, e.d});
      end
    end
  end

  task automatic send(input bit w, input logic [3:0] cls,
                      input logic [1:0] rw, input logic [1:0] ra,
                      input logic [1:0] rb, input logic [3:0] op,
                      input logic [2:0] cond, input logic [15:0] imm);
    int n;
    @(negedge clk);
    cmd_cls = cls; cmd_rw = rw; cmd_ra = ra; cmd_rb = rb;
    cmd_op = op; cmd_cond = cond; cmd_imm = imm;
    if (w) cmd_valid2 = 1; else cmd_valid = 1;
    n = 0;
    while (!(w ? rdy2 : rdy) && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) chk("ready_timeout", 0, 1);
    @(posedge clk);
    #1;
    cmd_valid = 0;
    cmd_valid2 = 0;
  endtask

  task automatic pulse(input bit w);
    @(negedge clk);
    if (w) start2 = 1; else start = 1;
    #1;
    chk("ready_in_start", {31'h0, w ? rdy2 : rdy}, 0);
    @(negedge clk);
    start = 0;
    start2 = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    chk("rst_ready", {31'h0, rdy}, 0);
    chk("rst_we", {31'h0, we}, 0);
    chk("rst_addr", {24'h0, addr}, 0);
    chk("rst_wdata", {16'h0, wd}, 0);
    chk("rst_count", {24'h0, cnt}, 0);
    chk("rst_busy", {31'h0, busy}, 0);
    chk("rst_done", {31'h0, done}, 0);
    chk("rst_err", {31'h0, err}, 0);
    chk("rst_hold", {31'h0, hold}, 1);
    @(negedge clk);
    rst_n = 1;

    pulse(0);
    chk("run_busy", {31'h0, busy}, 1);
    push(8'd0, 16'h0505, 8'd1);
    send(0, 4'h2, 2'd1, 0, 0, 0, 0, 16'h0005);
    push(8'd1, 16'h4A34, 8'd2);
    push(8'd2, 16'h5A12, 8'd3);
    send(0, 4'hD, 2'd2, 0, 0, 0, 0, 16'h1234);
    chk("exp2_ready", {31'h0, rdy}, 0);
    push(8'd3, 16'h2B16, 8'd4);
    send(0, 4'h3, 2'd3, 2'd1, 2'd2, 4'h1, 0, 16'h0);
    push(8'd4, 16'h25FE, 8'd5);
    send(0, 4'h8, 0, 0, 0, 0, 3'b101, 16'hFFFE);
    push(8'd5, 16'hC67F, 8'd6);
    send(0, 4'h4, 2'd1, 2'd2, 0, 0, 0, 16'h007F);
    push(8'd6, 16'hF280, 8'd7);
    send(0, 4'h9, 0, 2'd2, 0, 0, 3'b010, 16'hFF80);
    push(8'd7, 16'h9710, 8'd8);
    send(0, 4'h7, 0, 2'd1, 2'd3, 0, 0, 16'h0010);
    push(8'd8, 16'h0119, 8'd9);
    send(0, 4'hA, 0, 2'd2, 2'd1, 0, 0, 16'h0);
    push(8'd9, 16'h5455, 8'd10);
    send(0, 4'hC, 2'd1, 0, 2'd0, 0, 0, 16'hAB55);
    push(8'd10, 16'h0000, 8'd11);
    send(0, 4'h0, 0, 0, 0, 0, 0, 16'h0);
    chk("no_err_yet", {31'h0, err}, 0);
    send(0, 4'h6, 2'd0, 2'd1, 0, 0, 0, 16'h0180);
    chk("range_err", {31'h0, err}, 1);
    push(8'd11, 16'h0001, 8'd12);
    send(0, 4'hE, 0, 0, 0, 0, 0, 16'h0);
    chk("end_done", {31'h0, done}, 1);
    chk("end_hold", {31'h0, hold}, 0);
    chk("end_busy", {31'h0, busy}, 0);
    chk("end_err_sticky", {31'h0, err}, 1);

    pulse(0);
    chk("restart_err", {31'h0, err}, 0);
    chk("restart_done", {31'h0, done}, 0);
    chk("restart_count", {24'h0, cnt}, 0);
    chk("restart_addr", {24'h0, addr}, 0);
    chk("restart_hold", {31'h0, hold}, 1);
    send(0, 4'hF, 0, 0, 0, 0, 0, 16'h0);
    chk("illegal_err", {31'h0, err}, 1);
    pulse(0);
    chk("start_clr_err", {31'h0, err}, 0);
    push(8'd0, 16'h4FEF, 8'd1);
    push(8'd1, 16'h5FBE, 8'd2);
    send(0, 4'hD, 2'd3, 0, 0, 0, 0, 16'hBEEF);
    chk("exp2_ready_b", {31'h0, rdy}, 0);
    chk("exp2_busy", {31'h0, busy}, 1);
    push(8'd2, 16'h45FF, 8'd3);
    send(0, 4'hD, 2'd1, 0, 0, 0, 0, 16'h00FF);
    chk("exp2_ready_c", {31'h0, rdy}, 0);
    @(negedge clk);
    #2;
    rst_n = 0;
    #1;
    chk("mid_rst_we", {31'h0, we}, 0);
    chk("mid_rst_ready", {31'h0, rdy}, 0);
    chk("mid_rst_busy", {31'h0, busy}, 0);
    chk("mid_rst_err", {31'h0, err}, 0);
    chk("mid_rst_hold", {31'h0, hold}, 1);
    chk("mid_rst_count", {24'h0, cnt}, 0);
    chk("mid_rst_addr", {24'h0, addr}, 0);
    chk("mid_rst_wdata", {16'h0, wd}, 0);
    @(negedge clk);
    rst_n = 1;
    repeat (3) @(negedge clk);
    pulse(0);
    push(8'd0, 16'h047F, 8'd1);
    send(0, 4'h2, 2'd0, 0, 0, 0, 0, 16'h007F);
    push(8'd1, 16'h0001, 8'd2);
    send(0, 4'hE, 0, 0, 0, 0, 0, 16'h0);
    chk("restart_done2", {31'h0, done}, 1);

    pulse(1);
    for (int k = 1; k <= 5; k++) begin
      if (k <= 4)
        push2(8'(k - 1), 16'h0500 | 16'(k), 8'(k));
      send(1, 4'h2, 2'd1, 0, 0, 0, 0, 16'(k));
      chk("ovf_err_k", {31'h0, err2}, (k == 5) ? 1 : 0);
    end
    send(1, 4'hE, 0, 0, 0, 0, 0, 16'h0);
    chk("ovf_done", {31'h0, done2}, 1);
    chk("ovf_hold", {31'h0, hold2}, 0);
    chk("ovf_err_stays", {31'h0, err2}, 1);
    chk("ovf_addr_hold", {30'h0, addr2}, 3);
    repeat (2) @(negedge clk);
    chk("ovf_writes", n2, 4);
    chk("q_empty", q.size(), 0);
    chk("q2_empty", q2.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
